// File: rtl/mod30_seq_checker.sv
// mod30_seq_checker
// Watches the value stream of an upstream modulo-MOD counter. It locks onto the
// stream after LOCK_N consecutive correct increments. While locked it counts
// wraps (MOD-1 -> 0) modulo WRAP_MOD and reports sequence errors. Every output
// is registered.
module mod30_seq_checker #(
    parameter int MOD      = 30,
    parameter int WRAP_MOD = 12,
    parameter int LOCK_N   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] cnt_in,
    input  logic       cnt_vld,
    input  logic       clr_err,
    output logic       locked,
    output logic       wrap_pulse,
    output logic [3:0] wrap_cnt,
    output logic       err_pulse,
    output logic       err_sticky,
    output logic [7:0] err_cnt
);

    // The match counter only has to reach LOCK_N.
    localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

    // Last value the upstream counter produces before it wraps.
    localparam logic [4:0] LAST_VAL = 5'(MOD - 1);

    // Last wrap_cnt value before it returns to zero.
    localparam logic [3:0] WRAP_LAST = 4'(WRAP_MOD - 1);

    // Lock threshold at the width of the match counter.
    localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_N);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      prev;
    logic [MW-1:0]   match;

    logic            in_range;
    logic [4:0]      expected;
    logic            hit;
    logic [MW-1:0]   match_inc;
    logic            err_evt;
    logic            wrap_evt;

    // Value that should follow p in a modulo-MOD count.
    function automatic logic [4:0] next_expected(input logic [4:0] p);
        if (p == LAST_VAL) begin
            return 5'd0;
        end else begin
            return p + 5'd1;
        end
    endfunction

    // Classify the current sample against the previously accepted value.
    always_comb begin
        in_range  = ({1'b0, cnt_in} < 6'(MOD));
        expected  = next_expected(prev);
        hit       = (cnt_in == expected);
        match_inc = match + MW'(1);
        err_evt   = 1'b0;
        wrap_evt  = 1'b0;
        if (cnt_vld && (state == LOCKED)) begin
            err_evt  = !in_range || !hit;
            wrap_evt = in_range && (prev == LAST_VAL) && (cnt_in == 5'd0);
        end else begin
            err_evt  = 1'b0;
            wrap_evt = 1'b0;
        end
    end

    // Lock state machine: tracks prev and match, and drives the locked flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= UNLOCKED;
            prev   <= 5'd0;
            match  <= '0;
            locked <= 1'b0;
        end else if (cnt_vld) begin
            case (state)
                UNLOCKED: begin
                    locked <= 1'b0;
                    match  <= '0;
                    if (in_range) begin
                        prev  <= cnt_in;
                        state <= LOCKING;
                    end else begin
                        state <= UNLOCKED;
                    end
                end
                LOCKING: begin
                    if (!in_range) begin
                        state  <= UNLOCKED;
                        match  <= '0;
                        locked <= 1'b0;
                    end else if (hit) begin
                        prev  <= cnt_in;
                        match <= match_inc;
                        if (match_inc == LOCK_TGT) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= LOCKING;
                            locked <= 1'b0;
                        end
                    end else begin
                        prev   <= cnt_in;
                        match  <= '0;
                        locked <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (!in_range) begin
                        // A value the counter can never produce: start over.
                        state  <= UNLOCKED;
                        match  <= '0;
                        locked <= 1'b0;
                    end else if (!hit) begin
                        prev   <= cnt_in;
                        match  <= '0;
                        state  <= LOCKING;
                        locked <= 1'b0;
                    end else begin
                        prev   <= cnt_in;
                        locked <= 1'b1;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    prev   <= 5'd0;
                    match  <= '0;
                    locked <= 1'b0;
                end
            endcase
        end else begin
            locked <= (state == LOCKED);
        end
    end

    // Wrap pulse and the modulo-WRAP_MOD wrap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_pulse <= 1'b0;
            wrap_cnt   <= 4'd0;
        end else begin
            wrap_pulse <= wrap_evt;
            if (wrap_evt) begin
                if (wrap_cnt == WRAP_LAST) begin
                    wrap_cnt <= 4'd0;
                end else begin
                    wrap_cnt <= wrap_cnt + 4'd1;
                end
            end else begin
                wrap_cnt <= wrap_cnt;
            end
        end
    end

    // Error pulse, sticky flag and saturating error counter. A new error on
    // the same edge as clr_err leaves exactly that one error recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            err_pulse <= err_evt;
            if (err_evt) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end else begin
                err_sticky <= err_sticky;
            end
            if (err_evt && clr_err) begin
                err_cnt <= 8'd1;
            end else if (clr_err) begin
                err_cnt <= 8'd0;
            end else if (err_evt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end else begin
                err_cnt <= err_cnt;
            end
        end
    end

endmodule
